// File: rtl/osnt_sume_axis_pkg.sv
// Shared constants and byte/keep helpers for the OSNT SUME AXI-Stream width converters.
// Wide beats are 32 bytes, split into four 8-byte segments.
package osnt_sume_axis_pkg;

  localparam int C_RATIO      = 4;
  localparam int C_SEG_BYTES  = 8;
  localparam int C_WIDE_BYTES = C_RATIO * C_SEG_BYTES;
  localparam int C_WIDE_W     = C_WIDE_BYTES * 8;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_SEND  = 1'b1;

  // Swaps byte order across the whole wide word: packet byte 0 moves from the MSB byte to bits [7:0].
  function automatic logic [C_WIDE_W-1:0] byte_reverse(input logic [C_WIDE_W-1:0] din);
    logic [C_WIDE_W-1:0] dout;
    dout = {C_WIDE_W{1'b0}};
    for (int i = 0; i < C_WIDE_BYTES; i++) begin
      dout[8*i +: 8] = din[C_WIDE_W-8-8*i +: 8];
    end
    return dout;
  endfunction

  function automatic logic [C_WIDE_BYTES-1:0] keep_reverse(input logic [C_WIDE_BYTES-1:0] kin);
    logic [C_WIDE_BYTES-1:0] kout;
    kout = {C_WIDE_BYTES{1'b0}};
    for (int i = 0; i < C_WIDE_BYTES; i++) begin
      kout[i] = kin[C_WIDE_BYTES-1-i];
    end
    return kout;
  endfunction

  // keep_le is already in little-endian byte order (bit n = packet byte n).
  function automatic logic seg_has_keep(input logic [C_WIDE_BYTES-1:0] keep_le, input logic [1:0] seg);
    return |keep_le[seg*C_SEG_BYTES +: C_SEG_BYTES];
  endfunction

endpackage

// File: rtl/osnt_sume_axis_be_le_downsizer.sv
// 256-bit big-endian to 64-bit little-endian AXI4-Stream downsizer: one wide beat is held
// and emitted as up to four narrow segments, trailing empty segments dropped on the last beat.
module osnt_sume_axis_be_le_downsizer
  import osnt_sume_axis_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 256,
  parameter int C_M_AXIS_TDATA_WIDTH = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int C_M_BYTES = C_M_AXIS_TDATA_WIDTH / 8;

  logic [0:0]                       state_r;
  logic [C_S_AXIS_TDATA_WIDTH-1:0]  data_r;
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] keep_r;
  logic                             last_r;
  logic [1:0]                       seg_r;
  logic [1:0]                       last_seg_r;
  logic                             sop_r;

  logic [C_M_AXIS_TDATA_WIDTH-1:0]  m_tdata_r;
  logic [C_M_BYTES-1:0]             m_tkeep_r;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  m_tuser_r;
  logic                             m_tvalid_r;
  logic                             m_tlast_r;

  logic [C_S_AXIS_TDATA_WIDTH-1:0]   in_data_le_s;
  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] in_keep_le_s;
  logic [1:0]                        in_last_seg_s;
  logic [1:0]                        seg_nxt_s;
  logic                              seg_done_s;
  logic                              s_tready_s;
  logic                              in_hs_s;
  logic                              out_hs_s;

  // Input reordering, last-segment selection and handshake decode.
  always_comb begin
    in_data_le_s = byte_reverse(S_AXIS_TDATA);
    in_keep_le_s = keep_reverse(S_AXIS_TKEEP);
    if (S_AXIS_TLAST) begin
      // An all-zero keep still produces one segment so TLAST is never lost.
      in_last_seg_s = seg_has_keep(in_keep_le_s, 2'd3) ? 2'd3 :
                      seg_has_keep(in_keep_le_s, 2'd2) ? 2'd2 :
                      seg_has_keep(in_keep_le_s, 2'd1) ? 2'd1 : 2'd0;
    end else begin
      in_last_seg_s = 2'd3;
    end
    seg_nxt_s  = seg_r + 2'd1;
    seg_done_s = (seg_r == last_seg_r);
    s_tready_s = ARESETN && ((state_r == ST_EMPTY) || (M_AXIS_TREADY && seg_done_s));
    in_hs_s    = S_AXIS_TVALID && s_tready_s;
    out_hs_s   = m_tvalid_r && M_AXIS_TREADY;
  end

  // FSM, holding register and registered output segment.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_r    <= ST_EMPTY;
      data_r     <= {C_S_AXIS_TDATA_WIDTH{1'b0}};
      keep_r     <= {(C_S_AXIS_TDATA_WIDTH/8){1'b0}};
      last_r     <= 1'b0;
      seg_r      <= 2'd0;
      last_seg_r <= 2'd0;
      sop_r      <= 1'b1;
      m_tdata_r  <= {C_M_AXIS_TDATA_WIDTH{1'b0}};
      m_tkeep_r  <= {C_M_BYTES{1'b0}};
      m_tuser_r  <= {C_M_AXIS_TUSER_WIDTH{1'b0}};
      m_tvalid_r <= 1'b0;
      m_tlast_r  <= 1'b0;
    end else if (in_hs_s) begin
      // New beat: either from EMPTY or replacing a completing last segment with no bubble.
      state_r    <= ST_SEND;
      data_r     <= in_data_le_s;
      keep_r     <= in_keep_le_s;
      last_r     <= S_AXIS_TLAST;
      seg_r      <= 2'd0;
      last_seg_r <= in_last_seg_s;
      sop_r      <= S_AXIS_TLAST;
      m_tdata_r  <= in_data_le_s[C_M_AXIS_TDATA_WIDTH-1:0];
      m_tkeep_r  <= in_keep_le_s[C_M_BYTES-1:0];
      m_tuser_r  <= sop_r ? S_AXIS_TUSER : {C_M_AXIS_TUSER_WIDTH{1'b0}};
      m_tvalid_r <= 1'b1;
      m_tlast_r  <= S_AXIS_TLAST && (in_last_seg_s == 2'd0);
    end else if (out_hs_s) begin
      if (seg_done_s) begin
        state_r    <= ST_EMPTY;
        m_tvalid_r <= 1'b0;
        m_tlast_r  <= 1'b0;
      end else begin
        seg_r     <= seg_nxt_s;
        m_tdata_r <= data_r[seg_nxt_s*C_M_AXIS_TDATA_WIDTH +: C_M_AXIS_TDATA_WIDTH];
        m_tkeep_r <= keep_r[seg_nxt_s*C_M_BYTES +: C_M_BYTES];
        m_tuser_r <= {C_M_AXIS_TUSER_WIDTH{1'b0}};
        m_tlast_r <= last_r && (seg_nxt_s == last_seg_r);
      end
    end
  end

  assign S_AXIS_TREADY = s_tready_s;
  assign M_AXIS_TDATA  = m_tdata_r;
  assign M_AXIS_TKEEP  = m_tkeep_r;
  assign M_AXIS_TUSER  = m_tuser_r;
  assign M_AXIS_TVALID = m_tvalid_r;
  assign M_AXIS_TLAST  = m_tlast_r;

endmodule

// File: tb/tb_osnt_sume_axis_be_le_downsizer.sv
// Directed bench for the BE-256 to LE-64 downsizer: per-beat scoreboard from a byte-level
// reference, plus hand-computed spot values for data, keep, beat counts and reset recovery.
module tb_osnt_sume_axis_be_le_downsizer;

  logic         aclk;
  logic         aresetn;
  logic [255:0] s_tdata;
  logic [31:0]  s_tkeep;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready = 1'b1;

  typedef struct packed {
    logic [63:0]  d;
    logic [7:0]   k;
    logic         l;
    logic [127:0] u;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        mon_e;
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           beat_cnt = 0;
  logic [63:0]  first_data;
  logic [127:0] first_user;
  logic [7:0]   fin_keep;
  logic         fin_last;
  logic         mon_en = 1'b1;
  logic         bp_en = 1'b0;
  logic [3:0]   bp_pat = 4'b1001;
  int           bp_ph = 0;
  logic [31:0]  ones = 32'hFFFF_FFFF;

  osnt_sume_axis_be_le_downsizer dut (
    .ACLK          (aclk),
    .ARESETN       (aresetn),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TKEEP  (s_tkeep),
    .S_AXIS_TUSER  (s_tuser),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TKEEP  (m_tkeep),
    .M_AXIS_TUSER  (m_tuser),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Downstream ready: constant 1 or the 1,0,0,1 pattern, changed just after each edge.
  always @(posedge aclk) begin
    #1;
    if (bp_en) begin
      m_tready = bp_pat[bp_ph];
      bp_ph = (bp_ph + 1) % 4;
    end else begin
      m_tready = 1'b1;
    end
  end

  task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pack_be(input logic [7:0] base);
    logic [255:0] d;
    for (int n = 0; n < 32; n++) d[255-8*n -: 8] = base + 8'(n);
    return d;
  endfunction

  // Reference: segment s lane j carries packet byte 8s+j.
  task automatic push_exp(input logic [255:0] d, input logic [31:0] keep, input logic last,
                          input logic first, input logic [127:0] u);
    int ls;
    beat_t b;
    ls = 3;
    if (last) begin
      ls = 0;
      for (int s = 0; s < 4; s++)
        for (int j = 0; j < 8; j++)
          if (keep[31-(8*s+j)]) ls = s;
    end
    for (int s = 0; s <= ls; s++) begin
      for (int j = 0; j < 8; j++) begin
        b.d[8*j +: 8] = d[255-8*(8*s+j) -: 8];
        b.k[j]        = keep[31-(8*s+j)];
      end
      b.l = last && (s == ls);
      b.u = (first && s == 0) ? u : 128'd0;
      exp_q.push_back(b);
    end
  endtask

  // Caller is just past a rising edge; returns just past the handshake edge.
  task automatic send_beat(input logic [255:0] d, input logic [31:0] keep, input logic [127:0] u,
                           input logic last, output int hs);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = keep; s_tuser = u; s_tlast = last; s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (!s_tready) check_vec("in_hs_timeout", 128'(s_tready), 128'd1);
    @(posedge aclk);
    #1;
    hs = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge aclk);
      n++;
    end
    check_vec("drain", 128'(exp_q.size()), 128'd0);
    @(posedge aclk);
    #1;
  endtask

  // Output monitor: every valid cycle must show the scoreboard head, stalled or not.
  always @(negedge aclk) begin
    if (mon_en && m_tvalid) begin
      if (exp_q.size() == 0) begin
        check_vec("unexpected_beat", 128'(m_tvalid), 128'd0);
      end else begin
        mon_e = exp_q[0];
        check_vec("data", 128'(m_tdata), 128'(mon_e.d));
        check_vec("keep", 128'(m_tkeep), 128'(mon_e.k));
        check_vec("last", 128'(m_tlast), 128'(mon_e.l));
        check_vec("user", m_tuser, mon_e.u);
        if (m_tready) begin
          void'(exp_q.pop_front());
          beat_cnt++;
          if (beat_cnt == 1) begin
            first_data = m_tdata;
            first_user = m_tuser;
          end
          fin_keep = m_tkeep;
          fin_last = m_tlast;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1, h2, n;
    aresetn = 1'b0; s_tdata = 256'd0; s_tkeep = 32'd0; s_tuser = 128'd0;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_vec("rst_tvalid", 128'(m_tvalid), 128'd0);
    check_vec("rst_tdata",  128'(m_tdata),  128'd0);
    check_vec("rst_tkeep",  128'(m_tkeep),  128'd0);
    check_vec("rst_tuser",  m_tuser,        128'd0);
    check_vec("rst_tlast",  128'(m_tlast),  128'd0);
    check_vec("rst_tready", 128'(s_tready), 128'd0);
    @(posedge aclk); #1; aresetn = 1'b1;
    @(negedge aclk);
    check_vec("tready_after_rst", 128'(s_tready), 128'd1);
    @(posedge aclk); #1;

    // 64-byte packet, full keep, no backpressure.
    beat_cnt = 0;
    push_exp(pack_be(8'h00), ones, 1'b0, 1'b1, 128'h0);
    push_exp(pack_be(8'h20), ones, 1'b1, 1'b0, 128'h0);
    send_beat(pack_be(8'h00), ones, 128'h0, 1'b0, h1);
    send_beat(pack_be(8'h20), ones, 128'h0, 1'b1, h2);
    wait_drain();
    check_vec("p64_beats", 128'(beat_cnt), 128'd8);
    check_vec("p64_first", 128'(first_data), 128'h0706050403020100);
    check_vec("p64_gap", 128'(h2 - h1), 128'd4);
    check_vec("p64_tlast", 128'(fin_last), 128'd1);

    // 40-byte packet: last beat keeps only segment 0.
    beat_cnt = 0;
    push_exp(pack_be(8'h40), ones, 1'b0, 1'b1, 128'h11);
    push_exp(pack_be(8'h60), 32'hFF00_0000, 1'b1, 1'b0, 128'h0);
    send_beat(pack_be(8'h40), ones, 128'h11, 1'b0, h1);
    send_beat(pack_be(8'h60), 32'hFF00_0000, 128'h0, 1'b1, h2);
    wait_drain();
    check_vec("p40_beats", 128'(beat_cnt), 128'd5);
    check_vec("p40_keep", 128'(fin_keep), 128'hFF);
    check_vec("p40_tlast", 128'(fin_last), 128'd1);

    // 28-byte single-beat packet.
    beat_cnt = 0;
    push_exp(pack_be(8'h80), 32'hFFFF_FFF0, 1'b1, 1'b1, 128'h22);
    send_beat(pack_be(8'h80), 32'hFFFF_FFF0, 128'h22, 1'b1, h1);
    wait_drain();
    check_vec("p28_beats", 128'(beat_cnt), 128'd4);
    check_vec("p28_keep", 128'(fin_keep), 128'h0F);
    check_vec("p28_tlast", 128'(fin_last), 128'd1);

    // Last beat with empty keep still yields one TLAST beat.
    beat_cnt = 0;
    push_exp(pack_be(8'hA0), 32'h0, 1'b1, 1'b1, 128'h0);
    send_beat(pack_be(8'hA0), 32'h0, 128'h0, 1'b1, h1);
    wait_drain();
    check_vec("p0_beats", 128'(beat_cnt), 128'd1);
    check_vec("p0_keep", 128'(fin_keep), 128'h00);
    check_vec("p0_tlast", 128'(fin_last), 128'd1);

    // Backpressure 1,0,0,1 with TUSER 0xA5, non-contiguous last keep, then a follow-on packet.
    @(negedge aclk); bp_en = 1'b1;
    @(posedge aclk); #1;
    beat_cnt = 0;
    push_exp(pack_be(8'hC0), ones, 1'b0, 1'b1, 128'hA5);
    push_exp(pack_be(8'hE0), 32'hF0F0_0F0F, 1'b1, 1'b0, 128'h0);
    push_exp(pack_be(8'h10), ones, 1'b1, 1'b1, 128'h5A);
    send_beat(pack_be(8'hC0), ones, 128'hA5, 1'b0, h1);
    send_beat(pack_be(8'hE0), 32'hF0F0_0F0F, 128'h0, 1'b1, h2);
    send_beat(pack_be(8'h10), ones, 128'h5A, 1'b1, h2);
    wait_drain();
    check_vec("bp_beats", 128'(beat_cnt), 128'd12);
    check_vec("bp_user1", first_user, 128'hA5);
    @(negedge aclk); bp_en = 1'b0;
    @(posedge aclk); #1;

    // Reset after output beat 2 of a non-last beat.
    beat_cnt = 0;
    push_exp(pack_be(8'h50), ones, 1'b0, 1'b1, 128'h33);
    send_beat(pack_be(8'h50), ones, 128'h33, 1'b0, h1);
    n = 0;
    while (beat_cnt < 2 && n < 50) begin
      @(posedge aclk);
      n++;
    end
    check_vec("rst_pre_beats", 128'(beat_cnt), 128'd2);
    #1; aresetn = 1'b0; mon_en = 1'b0; exp_q.delete();
    @(negedge aclk);
    check_vec("rst_mid_tready", 128'(s_tready), 128'd0);
    @(posedge aclk); #1; aresetn = 1'b1;
    @(negedge aclk);
    check_vec("rst_mid_tvalid", 128'(m_tvalid), 128'd0);
    check_vec("rst_mid_tlast", 128'(m_tlast), 128'd0);
    check_vec("rst_mid_tready1", 128'(s_tready), 128'd1);
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check_vec("idle_after_rst", 128'(m_tvalid), 128'd0);
    end
    @(posedge aclk); #1;
    beat_cnt = 0;
    push_exp(pack_be(8'h70), ones, 1'b1, 1'b1, 128'h77);
    send_beat(pack_be(8'h70), ones, 128'h77, 1'b1, h1);
    wait_drain();
    check_vec("sop_restored_user", first_user, 128'h77);
    check_vec("post_rst_beats", 128'(beat_cnt), 128'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
